// File: rtl/avlst_arbiter_sched_if.sv
// Purpose: handshake/bus bundle between FIFO read sides, the channel arbiter and the downstream sink.
// Ports: requests, eops, enable and sink ready in; one-hot grant, mux select, busy flag and counters out.
// Modports: slave = arbiter side, master = channel/sink/control side.
interface avlst_arbiter_sched_if #(
    parameter int CHAN_NUM   = 4,
    parameter int CHAN_WIDTH = $clog2(CHAN_NUM)
);
    logic                  arb_enable;
    logic [2*CHAN_NUM-1:0] arbit_request;
    logic [CHAN_NUM-1:0]   arbit_eop;
    logic                  dout_ready;
    logic [CHAN_NUM-1:0]   arbit_grant;
    logic [CHAN_WIDTH-1:0] chan_sel;
    logic                  chan_active;
    logic [31:0]           pack_cnt;
    logic [31:0]           timeout_cnt;

    modport slave (
        input  arb_enable, arbit_request, arbit_eop, dout_ready,
        output arbit_grant, chan_sel, chan_active, pack_cnt, timeout_cnt
    );

    modport master (
        output arb_enable, arbit_request, arbit_eop, dout_ready,
        input  arbit_grant, chan_sel, chan_active, pack_cnt, timeout_cnt
    );
endinterface

// File: rtl/avlst_arbiter_sched.sv
// Purpose: packet-granular round-robin arbiter over CHAN_NUM FIFOs, critical class first, IDLE/BUSY/GAP.
// Latency: grant one edge after an eligible IDLE cycle; GAP_LEN idle cycles after every release.
// Backpressure: granted channel's grant bit follows dout_ready combinationally; eop counts only when ready.
// Ports: clk, rst_n (sync, active-low) plain; everything else through bus (slave modport).
module avlst_arbiter_sched #(
    parameter int CHAN_NUM    = 4,
    parameter int CHAN_WIDTH  = $clog2(CHAN_NUM),
    parameter int TIMEOUT_LEN = 4096,
    parameter int GAP_LEN     = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    avlst_arbiter_sched_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t                state;
    logic [15:0]           cyc_cnt;
    logic [3:0]            gap_cnt;
    logic [CHAN_WIDTH-1:0] last_sel;
    logic [CHAN_WIDTH-1:0] chan_sel_q;
    logic                  chan_active_q;
    logic [31:0]           pack_cnt_q;
    logic [31:0]           timeout_cnt_q;

    logic [CHAN_NUM-1:0]   gen_req;
    logic [CHAN_NUM-1:0]   crit_req;
    logic [CHAN_NUM-1:0]   cand;
    logic [CHAN_WIDTH-1:0] winner;
    logic                  win_vld;
    logic                  eop_accept;
    logic                  cyc_expired;

    // A critical bit only counts when the general bit of the same channel is set.
    always_comb begin
        gen_req  = '0;
        crit_req = '0;
        for (int n = 0; n < CHAN_NUM; n++) begin
            gen_req[n]  = bus.arbit_request[2*n];
            crit_req[n] = bus.arbit_request[2*n+1] & bus.arbit_request[2*n];
        end
        cand = (|crit_req) ? crit_req : gen_req;
    end

    // Round-robin scan from last_sel+1. Walking the offsets from the far end
    // down lets the nearest candidate overwrite the farther ones.
    always_comb begin
        logic [CHAN_WIDTH-1:0] idx;
        winner  = '0;
        idx     = '0;
        win_vld = |cand;
        for (int i = CHAN_NUM; i >= 1; i--) begin
            idx = CHAN_WIDTH'((int'(last_sel) + i) % CHAN_NUM);
            if (cand[idx]) begin
                winner = idx;
            end
        end
    end

    assign eop_accept  = bus.dout_ready & bus.arbit_eop[chan_sel_q];
    assign cyc_expired = (cyc_cnt == 16'(TIMEOUT_LEN - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            cyc_cnt       <= '0;
            gap_cnt       <= '0;
            last_sel      <= CHAN_WIDTH'(CHAN_NUM - 1);
            chan_sel_q    <= '0;
            chan_active_q <= 1'b0;
            pack_cnt_q    <= '0;
            timeout_cnt_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.arb_enable && win_vld) begin
                        state         <= BUSY;
                        chan_sel_q    <= winner;
                        chan_active_q <= 1'b1;
                        cyc_cnt       <= '0;
                    end
                end
                BUSY: begin
                    cyc_cnt <= cyc_cnt + 16'd1;
                    // Accepted eop wins over a timeout landing on the same cycle.
                    if (eop_accept) begin
                        state         <= GAP;
                        chan_active_q <= 1'b0;
                        last_sel      <= chan_sel_q;
                        gap_cnt       <= '0;
                        pack_cnt_q    <= pack_cnt_q + 32'd1;
                    end else if (cyc_expired) begin
                        state         <= GAP;
                        chan_active_q <= 1'b0;
                        last_sel      <= chan_sel_q;
                        gap_cnt       <= '0;
                        timeout_cnt_q <= timeout_cnt_q + 32'd1;
                    end
                end
                GAP: begin
                    if (gap_cnt == 4'(GAP_LEN - 1)) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 4'd1;
                    end
                end
                default: begin
                    state         <= IDLE;
                    chan_active_q <= 1'b0;
                end
            endcase
        end
    end

    // Grant doubles as the FIFO read-ready, so it must track dout_ready in the same cycle.
    always_comb begin
        bus.arbit_grant = '0;
        if (chan_active_q) begin
            bus.arbit_grant[chan_sel_q] = bus.dout_ready;
        end
    end

    assign bus.chan_sel    = chan_sel_q;
    assign bus.chan_active = chan_active_q;
    assign bus.pack_cnt    = pack_cnt_q;
    assign bus.timeout_cnt = timeout_cnt_q;
endmodule

// File: tb/tb_avlst_arbiter_sched.sv
module tb_avlst_arbiter_sched;
    localparam int N   = 4;
    localparam int TMO = 8;
    localparam int GAP = 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    avlst_arbiter_sched_if #(.CHAN_NUM(N), .CHAN_WIDTH(2)) bus ();

    avlst_arbiter_sched #(
        .CHAN_NUM(N), .CHAN_WIDTH(2), .TIMEOUT_LEN(TMO), .GAP_LEN(GAP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errs   = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n             = 1'b0;
        bus.arb_enable    = 1'b0;
        bus.arbit_request = '0;
        bus.arbit_eop     = '0;
        bus.dout_ready    = 1'b1;
        cyc();
        cyc();
        chk("rst_active", 32'(bus.chan_active), 32'd0);
        chk("rst_grant", 32'(bus.arbit_grant), 32'd0);
        chk("rst_sel", 32'(bus.chan_sel), 32'd0);
        chk("rst_pack", bus.pack_cnt, 32'd0);
        chk("rst_tmo", bus.timeout_cnt, 32'd0);
        rst_n = 1'b1;
    endtask

    task automatic wait_active(input int budget, output int edges);
        edges = 0;
        while (!bus.chan_active && edges < budget) begin
            cyc();
            edges++;
        end
        chk("grant_within_budget", 32'(bus.chan_active), 32'd1);
    endtask

    // Reference model: owner = granted channel or -1; age = BUSY cycles elapsed;
    // gap_left = idle cycles still owed after a release.
    int          m_owner, m_sel, m_age, m_gap, m_last;
    logic [31:0] m_pack, m_tmo;

    task automatic model_reset();
        m_owner = -1; m_sel = 0; m_age = 0; m_gap = 0; m_last = N - 1;
        m_pack = 0; m_tmo = 0;
    endtask

    function automatic int pick(input logic [7:0] req, input int last);
        int order[$];
        for (int k = 1; k <= N; k++) order.push_back((last + k) % N);
        foreach (order[j]) if (req[2*order[j]] && req[2*order[j]+1]) return order[j];
        foreach (order[j]) if (req[2*order[j]]) return order[j];
        return -1;
    endfunction

    task automatic model_step(input bit rst, input bit en, input logic [7:0] req,
                              input logic [3:0] eop, input bit rdy);
        int w;
        if (!rst) begin
            model_reset();
        end else if (m_owner >= 0) begin
            m_age++;
            if (eop[m_owner] && rdy) begin
                m_pack++; m_last = m_owner; m_owner = -1; m_gap = GAP;
            end else if (m_age == TMO) begin
                m_tmo++; m_last = m_owner; m_owner = -1; m_gap = GAP;
            end
        end else if (m_gap > 0) begin
            m_gap--;
        end else if (en) begin
            w = pick(req, m_last);
            if (w >= 0) begin
                m_owner = w; m_sel = w; m_age = 0;
            end
        end
    endtask

    typedef struct {
        string      name;
        logic [7:0] req;
        int         exp_sel;
    } arb_vec_t;

    arb_vec_t vecs[7];

    initial begin
        int edges, n, seen;
        logic [3:0] eg;
        bit r_rst, r_en, r_rdy;
        logic [7:0] r_req;
        logic [3:0] r_eop;

        vecs[0] = '{"tbl_all_general", 8'h55, 0};
        vecs[1] = '{"tbl_ch2_only",    8'h10, 2};
        vecs[2] = '{"tbl_crit_ch3",    8'hC4, 3};
        vecs[3] = '{"tbl_crit_no_gen", 8'h12, 2};
        vecs[4] = '{"tbl_two_crit",    8'h3C, 1};
        vecs[5] = '{"tbl_ch3_gen",     8'h42, 3};
        vecs[6] = '{"tbl_crit_over",   8'hD5, 3};

        // First grant out of reset for a set of request patterns.
        foreach (vecs[i]) begin
            do_reset();
            bus.arbit_request = vecs[i].req;
            bus.arb_enable    = 1'b1;
            cyc();
            chk({vecs[i].name, "_active"}, 32'(bus.chan_active), 32'd1);
            chk({vecs[i].name, "_sel"}, 32'(bus.chan_sel), 32'(vecs[i].exp_sel));
            chk({vecs[i].name, "_grant"}, 32'(bus.arbit_grant), 32'(1 << vecs[i].exp_sel));
        end

        // Round-robin with 4-cycle packets.
        do_reset();
        bus.arbit_request = 8'h55;
        bus.arb_enable    = 1'b1;
        for (int p = 0; p < 5; p++) begin
            wait_active(4, edges);
            chk("rr_edges_to_grant", 32'(edges), (p == 0) ? 32'd1 : 32'(GAP + 1));
            chk("rr_sel", 32'(bus.chan_sel), 32'(p % N));
            chk("rr_grant", 32'(bus.arbit_grant), 32'(1 << (p % N)));
            cyc(); cyc(); cyc();
            bus.arbit_eop = 4'(1 << (p % N));
            cyc();
            bus.arbit_eop = '0;
            chk("rr_release", 32'(bus.chan_active), 32'd0);
        end
        chk("rr_pack", bus.pack_cnt, 32'd5);
        chk("rr_tmo", bus.timeout_cnt, 32'd0);

        // Critical priority after last_sel = 0.
        do_reset();
        bus.arbit_request = 8'h01;
        bus.arb_enable    = 1'b1;
        wait_active(3, edges);
        chk("crit_setup_sel", 32'(bus.chan_sel), 32'd0);
        bus.arbit_eop = 4'h1;
        cyc();
        bus.arbit_eop     = '0;
        bus.arbit_request = 8'hC4;
        wait_active(4, edges);
        chk("crit_first", 32'(bus.chan_sel), 32'd3);
        bus.arbit_eop     = 4'h8;
        bus.arbit_request = 8'h04;
        cyc();
        bus.arbit_eop = '0;
        wait_active(4, edges);
        chk("crit_second", 32'(bus.chan_sel), 32'd1);

        // Backpressure on channel 2.
        do_reset();
        bus.arbit_request = 8'h10;
        bus.arb_enable    = 1'b1;
        wait_active(3, edges);
        chk("bp_sel", 32'(bus.chan_sel), 32'd2);
        for (int k = 0; k < 4; k++) begin
            bus.dout_ready = (k % 2 == 0);
            bus.arbit_eop  = (k % 2 == 0) ? 4'h0 : 4'h4;
            #1;
            chk("bp_grant_mirror", 32'(bus.arbit_grant), (k % 2 == 0) ? 32'h4 : 32'h0);
            cyc();
            chk("bp_hold", 32'(bus.chan_active), 32'd1);
        end
        bus.dout_ready = 1'b1;
        bus.arbit_eop  = 4'h4;
        cyc();
        bus.arbit_eop = '0;
        chk("bp_release", 32'(bus.chan_active), 32'd0);
        chk("bp_pack", bus.pack_cnt, 32'd1);

        // Timeout on channel 0; its request drops mid-packet.
        do_reset();
        bus.arbit_request = 8'h05;
        bus.arb_enable    = 1'b1;
        wait_active(3, edges);
        chk("to_sel", 32'(bus.chan_sel), 32'd0);
        n = 0;
        while (bus.chan_active && n < 20) begin
            n++;
            if (n == 2) bus.arbit_request = 8'h04;
            cyc();
        end
        chk("to_busy_cycles", 32'(n), 32'(TMO));
        chk("to_tmo", bus.timeout_cnt, 32'd1);
        chk("to_pack", bus.pack_cnt, 32'd0);
        wait_active(4, edges);
        chk("to_next_sel", 32'(bus.chan_sel), 32'd1);

        // Eop on the timeout cycle; other channels' eops ignored before it.
        for (int k = 1; k < TMO; k++) begin
            bus.arbit_eop = 4'hD;
            cyc();
        end
        chk("sim_still_busy", 32'(bus.chan_active), 32'd1);
        bus.arbit_eop = 4'h2;
        cyc();
        bus.arbit_eop = '0;
        chk("sim_release", 32'(bus.chan_active), 32'd0);
        chk("sim_pack", bus.pack_cnt, 32'd1);
        chk("sim_tmo", bus.timeout_cnt, 32'd1);

        // Reset mid-packet, then arb_enable gating.
        do_reset();
        bus.arbit_request = 8'h10;
        bus.arb_enable    = 1'b1;
        wait_active(3, edges);
        chk("mr_sel", 32'(bus.chan_sel), 32'd2);
        rst_n         = 1'b0;
        bus.arbit_eop = 4'h4;
        cyc();
        chk("mr_active", 32'(bus.chan_active), 32'd0);
        chk("mr_grant", 32'(bus.arbit_grant), 32'd0);
        chk("mr_sel_rst", 32'(bus.chan_sel), 32'd0);
        chk("mr_pack", bus.pack_cnt, 32'd0);
        chk("mr_tmo", bus.timeout_cnt, 32'd0);
        rst_n             = 1'b1;
        bus.arbit_eop     = '0;
        bus.arb_enable    = 1'b0;
        bus.arbit_request = 8'h55;
        seen = 0;
        repeat (6) begin
            cyc();
            if (bus.chan_active) seen++;
        end
        chk("en_off_no_grant", 32'(seen), 32'd0);
        bus.arb_enable = 1'b1;
        wait_active(2, edges);
        chk("en_on_sel", 32'(bus.chan_sel), 32'd0);
        bus.arb_enable = 1'b0;
        cyc(); cyc();
        chk("en_off_keeps_grant", 32'(bus.chan_active), 32'd1);
        bus.arbit_eop = 4'h1;
        cyc();
        bus.arbit_eop = '0;
        chk("en_off_complete", bus.pack_cnt, 32'd1);
        seen = 0;
        repeat (5) begin
            cyc();
            if (bus.chan_active) seen++;
        end
        chk("en_off_idle", 32'(seen), 32'd0);

        // Randomised traffic against the reference model.
        do_reset();
        model_reset();
        for (int i = 0; i < 1500; i++) begin
            r_rst = ($urandom % 150) != 0;
            r_en  = ($urandom % 6) != 0;
            r_req = 8'($urandom);
            r_eop = (($urandom % 4) == 0) ? 4'($urandom) : 4'h0;
            r_rdy = ($urandom % 4) != 0;
            rst_n             = r_rst;
            bus.arb_enable    = r_en;
            bus.arbit_request = r_req;
            bus.arbit_eop     = r_eop;
            bus.dout_ready    = r_rdy;
            #1;
            eg = (m_owner >= 0 && r_rdy) ? 4'(1 << m_owner) : 4'h0;
            chk("rnd_grant", 32'(bus.arbit_grant), 32'(eg));
            chk("rnd_active", 32'(bus.chan_active), (m_owner >= 0) ? 32'd1 : 32'd0);
            chk("rnd_sel", 32'(bus.chan_sel), 32'(m_sel));
            chk("rnd_pack", bus.pack_cnt, m_pack);
            chk("rnd_tmo", bus.timeout_cnt, m_tmo);
            @(posedge clk);
            model_step(r_rst, r_en, r_req, r_eop, r_rdy);
            #1;
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
